// File: rtl/csr_pkg.sv
// Shared CSR-bus definitions: default bus widths and the arbiter state encoding.
package csr_pkg;

   localparam int CSR_ADDR_W_DEF = 8;
   localparam int CSR_DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/csr_arb2_if.sv
// Two-master CSR bus bundle plus the single downstream CSR slave port.
interface csr_arb2_if
   import csr_pkg::*;
#(
   parameter int CSR_ADDR_W = CSR_ADDR_W_DEF,
   parameter int CSR_DATA_W = CSR_DATA_W_DEF
);

   logic                  m0_req, m0_gnt, m0_wen, m0_ren, m0_rvalid, m0_err;
   logic [CSR_ADDR_W-1:0] m0_addr;
   logic [CSR_DATA_W-1:0] m0_wdata, m0_rdata;

   logic                  m1_req, m1_gnt, m1_wen, m1_ren, m1_rvalid, m1_err;
   logic [CSR_ADDR_W-1:0] m1_addr;
   logic [CSR_DATA_W-1:0] m1_wdata, m1_rdata;

   logic                  s_wen, s_ren, s_rvalid;
   logic [CSR_ADDR_W-1:0] s_addr;
   logic [CSR_DATA_W-1:0] s_wdata, s_rdata;

   // Bridges and the CSR map side (environment view).
   modport master (
      output m0_req, m0_addr, m0_wen, m0_wdata, m0_ren,
      output m1_req, m1_addr, m1_wen, m1_wdata, m1_ren,
      output s_rvalid, s_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  s_addr, s_wen, s_wdata, s_ren
   );

   // Arbiter view.
   modport slave (
      input  m0_req, m0_addr, m0_wen, m0_wdata, m0_ren,
      input  m1_req, m1_addr, m1_wen, m1_wdata, m1_ren,
      input  s_rvalid, s_rdata,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output s_addr, s_wen, s_wdata, s_ren
   );

endinterface

// File: rtl/rr_arb2.sv
// 2-way round-robin picker: on a tie the master not served last wins.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] pick_o
);

   always_comb begin
      pick_o    = 2'b00;
      pick_o[0] = req_i[0] & (~req_i[1] | last_i);
      pick_o[1] = req_i[1] & (~req_i[0] | ~last_i);
   end

endmodule

// File: rtl/csr_arb2.sv
// Session arbiter sharing one CSR slave port between two bridges; grants whole
// sessions and issues exactly one downstream read per master read request.
module csr_arb2
   import csr_pkg::*;
#(
   parameter int CSR_ADDR_W = CSR_ADDR_W_DEF,
   parameter int CSR_DATA_W = CSR_DATA_W_DEF
) (
   input logic         clk,
   input logic         rst,
   csr_arb2_if.slave   bus
);

   arb_state_e            state_q, state_d;
   logic                  last_q, last_d;
   logic                  rd_done_q, rd_done_d;
   logic                  s_wen_q, s_wen_d, s_ren_q, s_ren_d;
   logic                  err0_q, err0_d, err1_q, err1_d;
   logic [CSR_ADDR_W-1:0] s_addr_q, s_addr_d;
   logic [CSR_DATA_W-1:0] s_wdata_q, s_wdata_d;

   logic                  own0, own1, hs, stay;
   logic                  owner_wen, owner_ren;
   logic [CSR_ADDR_W-1:0] owner_addr;
   logic [CSR_DATA_W-1:0] owner_wdata;
   logic [1:0]            pick;

   rr_arb2 u_pick (
      .req_i  ({bus.m1_req, bus.m0_req}),
      .last_i (last_q),
      .pick_o (pick)
   );

   assign own0 = (state_q == ST_OWN0);
   assign own1 = (state_q == ST_OWN1);
   assign hs   = s_ren_q & bus.s_rvalid;

   always_comb begin
      owner_wen   = 1'b0;
      owner_ren   = 1'b0;
      owner_addr  = bus.m0_addr;
      owner_wdata = bus.m0_wdata;
      if (own0) begin
         owner_wen = bus.m0_wen;
         owner_ren = bus.m0_ren;
      end else if (own1) begin
         owner_wen   = bus.m1_wen;
         owner_ren   = bus.m1_ren;
         owner_addr  = bus.m1_addr;
         owner_wdata = bus.m1_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick[0])      state_d = ST_OWN0;
            else if (pick[1]) state_d = ST_OWN1;
         end
         // A session only ends once no downstream read is in flight.
         ST_OWN0: if (!bus.m0_req && !s_ren_q) begin
            state_d = ST_IDLE;
            last_d  = 1'b0;
         end
         ST_OWN1: if (!bus.m1_req && !s_ren_q) begin
            state_d = ST_IDLE;
            last_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      stay      = (state_q != ST_IDLE) && (state_d == state_q);
      s_wen_d   = stay & owner_wen;
      s_ren_d   = stay & owner_ren & ~rd_done_q & ~hs;
      rd_done_d = hs | (owner_ren & rd_done_q);
      s_addr_d  = stay ? owner_addr  : s_addr_q;
      s_wdata_d = stay ? owner_wdata : s_wdata_q;
      err0_d    = err0_q | ((bus.m0_wen | bus.m0_ren) & ~own0);
      err1_d    = err1_q | ((bus.m1_wen | bus.m1_ren) & ~own1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_q    <= 1'b1;
         rd_done_q <= 1'b0;
         s_wen_q   <= 1'b0;
         s_ren_q   <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         rd_done_q <= rd_done_d;
         s_wen_q   <= s_wen_d;
         s_ren_q   <= s_ren_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
      end
   end

   assign bus.m0_gnt    = own0;
   assign bus.m1_gnt    = own1;
   assign bus.m0_rvalid = hs & own0;
   assign bus.m1_rvalid = hs & own1;
   assign bus.m0_rdata  = own0 ? bus.s_rdata : '0;
   assign bus.m1_rdata  = own1 ? bus.s_rdata : '0;
   assign bus.m0_err    = err0_q;
   assign bus.m1_err    = err1_q;
   assign bus.s_addr    = s_addr_q;
   assign bus.s_wen     = s_wen_q;
   assign bus.s_wdata   = s_wdata_q;
   assign bus.s_ren     = s_ren_q;

endmodule

// File: tb/tb_csr_arb2.sv
// Directed bench for csr_arb2: stimulus queues expected CSR writes and read
// returns; a negedge monitor pops and compares them as the DUT presents them.
module tb_csr_arb2;
   import csr_pkg::*;

   localparam int AW      = CSR_ADDR_W_DEF;
   localparam int DW      = CSR_DATA_W_DEF;
   localparam int CSR_DLY = 3;

   typedef struct packed {
      logic          is_rd;
      logic          mst;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   csr_arb2_if #(.CSR_ADDR_W(AW), .CSR_DATA_W(DW)) bus ();

   csr_arb2 #(.CSR_ADDR_W(AW), .CSR_DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t          exp_q[$];
   int            errors = 0;
   int            checks = 0;
   int            sren_rises = 0;
   logic          sren_prev = 1'b0;
   logic [DW-1:0] csr_data = '0;
   int            rcnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic rd, input logic m, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
      exp_t e;
      e.is_rd = rd;
      e.mst   = m;
      e.addr  = a;
      e.data  = d;
      return e;
   endfunction

   // CSR map model: answers a read after s_ren has been high for CSR_DLY cycles.
   assign bus.s_rdata = csr_data;
   always @(posedge clk) begin
      #1;
      if (bus.s_ren && !bus.s_rvalid) begin
         rcnt = rcnt + 1;
         if (rcnt >= CSR_DLY) bus.s_rvalid = 1'b1;
      end else begin
         bus.s_rvalid = 1'b0;
         rcnt         = 0;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (bus.s_ren && !sren_prev) sren_rises <= sren_rises + 1;
      sren_prev <= bus.s_ren;
      if (bus.s_wen) begin
         if (exp_q.size() == 0 || exp_q[0].is_rd) begin
            chk("unexpected s_wen", {31'd0, bus.s_wen}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("s_addr on write", {24'd0, bus.s_addr}, {24'd0, e.addr});
            chk("s_wdata on write", {16'd0, bus.s_wdata}, {16'd0, e.data});
         end
      end
      if (bus.m0_rvalid || bus.m1_rvalid) begin
         if (exp_q.size() == 0 || !exp_q[0].is_rd) begin
            chk("unexpected rvalid", {31'd0, bus.m0_rvalid | bus.m1_rvalid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rvalid master", {31'd0, bus.m1_rvalid}, {31'd0, e.mst});
            chk("rdata", {16'd0, e.mst ? bus.m1_rdata : bus.m0_rdata}, {16'd0, e.data});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_all();
      bus.m0_req = 1'b0; bus.m0_wen = 1'b0; bus.m0_ren = 1'b0;
      bus.m1_req = 1'b0; bus.m1_wen = 1'b0; bus.m1_ren = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      int n;
      int base;
      rst = 1'b1;
      idle_all();
      bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_addr = '0; bus.m1_wdata = '0;
      csr_data = 16'hA5A5;
      repeat (2) cyc();

      // Reset state
      chk("rst m0_gnt", {31'd0, bus.m0_gnt}, 0);
      chk("rst m1_gnt", {31'd0, bus.m1_gnt}, 0);
      chk("rst s_wen", {31'd0, bus.s_wen}, 0);
      chk("rst s_ren", {31'd0, bus.s_ren}, 0);
      chk("rst s_addr", {24'd0, bus.s_addr}, 0);
      chk("rst s_wdata", {16'd0, bus.s_wdata}, 0);
      chk("rst m0_err", {31'd0, bus.m0_err}, 0);
      chk("rst m1_err", {31'd0, bus.m1_err}, 0);
      chk("rst m0_rvalid", {31'd0, bus.m0_rvalid}, 0);
      chk("rst m0_rdata", {16'd0, bus.m0_rdata}, 0);
      chk("rst m1_rdata", {16'd0, bus.m1_rdata}, 0);
      rst = 1'b0;
      cyc();

      // Single master write
      bus.m0_req = 1'b1;
      cyc();
      chk("t1 m0_gnt", {31'd0, bus.m0_gnt}, 1);
      chk("t1 m1_gnt", {31'd0, bus.m1_gnt}, 0);
      bus.m0_addr = 8'h12; bus.m0_wdata = 16'hBEEF; bus.m0_wen = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 8'h12, 16'hBEEF));
      cyc();
      bus.m0_wen = 1'b0;
      chk("t1 s_wen", {31'd0, bus.s_wen}, 1);
      chk("t1 m1_gnt idle", {31'd0, bus.m1_gnt}, 0);
      chk("t1 m1_err", {31'd0, bus.m1_err}, 0);
      chk("t1 m1_rvalid", {31'd0, bus.m1_rvalid}, 0);
      chk("t1 m1_rdata", {16'd0, bus.m1_rdata}, 0);
      cyc();
      chk("t1 s_wen one cycle", {31'd0, bus.s_wen}, 0);
      bus.m0_req = 1'b0;
      cyc();
      chk("t1 m0_gnt drop", {31'd0, bus.m0_gnt}, 0);
      repeat (2) cyc();
      chk("t1 s_addr hold", {24'd0, bus.s_addr}, 32'h12);

      // Tie after reset, handover, tie again
      do_reset();
      bus.m0_req = 1'b1; bus.m1_req = 1'b1;
      cyc();
      chk("t2 tie m0_gnt", {31'd0, bus.m0_gnt}, 1);
      chk("t2 tie m1_gnt", {31'd0, bus.m1_gnt}, 0);
      bus.m0_req = 1'b0;
      cyc();
      chk("t2 handover idle m0", {31'd0, bus.m0_gnt}, 0);
      chk("t2 handover idle m1", {31'd0, bus.m1_gnt}, 0);
      cyc();
      chk("t2 handover m1_gnt", {31'd0, bus.m1_gnt}, 1);
      bus.m1_req = 1'b0;
      cyc();
      chk("t2 m1 release", {31'd0, bus.m1_gnt}, 0);
      bus.m0_req = 1'b1; bus.m1_req = 1'b1;
      cyc();
      chk("t2 retie m0_gnt", {31'd0, bus.m0_gnt}, 1);
      chk("t2 retie m1_gnt", {31'd0, bus.m1_gnt}, 0);
      bus.m1_req = 1'b0;

      // Read through a slow CSR
      base = sren_rises;
      csr_data = 16'hA5A5;
      bus.m0_addr = 8'h20; bus.m0_ren = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 8'h20, 16'hA5A5));
      n = 0;
      do begin cyc(); n++; end while (!bus.m0_rvalid && n < 20);
      chk("t3 rvalid latency", n, CSR_DLY);
      cyc();
      chk("t3 s_ren low after hs", {31'd0, bus.s_ren}, 0);
      bus.m0_ren = 1'b0;
      repeat (3) cyc();
      chk("t3 single s_ren interval", sren_rises - base, 1);

      // Non-owner write attempt while m0 writes
      bus.m1_addr = 8'h55; bus.m1_wdata = 16'h1111; bus.m1_wen = 1'b1;
      bus.m0_addr = 8'h34; bus.m0_wdata = 16'h1234; bus.m0_wen = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 8'h34, 16'h1234));
      cyc();
      bus.m1_wen = 1'b0; bus.m0_wen = 1'b0;
      chk("t4 m1_err set", {31'd0, bus.m1_err}, 1);
      chk("t4 m0_err clear", {31'd0, bus.m0_err}, 0);
      repeat (2) cyc();
      chk("t4 m1_err sticky", {31'd0, bus.m1_err}, 1);

      // Owner drops req mid-read
      csr_data = 16'h5A5A;
      bus.m0_addr = 8'h40; bus.m0_ren = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 8'h40, 16'h5A5A));
      cyc();
      bus.m0_req = 1'b0; bus.m1_req = 1'b1;
      n = 0;
      while (!bus.m0_rvalid && n < 20) begin cyc(); n++; end
      chk("t5 rvalid seen", {31'd0, bus.m0_rvalid}, 1);
      chk("t5 gnt held at hs", {31'd0, bus.m0_gnt}, 1);
      chk("t5 m1 waits", {31'd0, bus.m1_gnt}, 0);
      cyc();
      cyc();
      bus.m0_ren = 1'b0;
      n = 0;
      while (bus.m0_gnt && n < 10) begin cyc(); n++; end
      chk("t5 m0 released", {31'd0, bus.m0_gnt}, 0);
      chk("t5 idle gap m1", {31'd0, bus.m1_gnt}, 0);
      cyc();
      chk("t5 m1 granted", {31'd0, bus.m1_gnt}, 1);
      chk("t5 m0_err", {31'd0, bus.m0_err}, 0);

      // Reset during an m1 read
      bus.m1_addr = 8'h66; bus.m1_ren = 1'b1;
      cyc();
      chk("t6 s_ren before rst", {31'd0, bus.s_ren}, 1);
      rst = 1'b1;
      #1;
      chk("t6 rst s_ren", {31'd0, bus.s_ren}, 0);
      chk("t6 rst m1_gnt", {31'd0, bus.m1_gnt}, 0);
      chk("t6 rst s_addr", {24'd0, bus.s_addr}, 0);
      chk("t6 rst s_wdata", {16'd0, bus.s_wdata}, 0);
      chk("t6 rst m1_err", {31'd0, bus.m1_err}, 0);
      chk("t6 rst m1_rdata", {16'd0, bus.m1_rdata}, 0);
      idle_all();
      cyc();
      rst = 1'b0;
      cyc();
      bus.m0_req = 1'b1; bus.m1_req = 1'b1;
      cyc();
      chk("t6 tie m0_gnt", {31'd0, bus.m0_gnt}, 1);
      chk("t6 tie m1_gnt", {31'd0, bus.m1_gnt}, 0);
      idle_all();
      repeat (4) cyc();
      chk("scoreboard drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
